// File: rtl/regfile_sb.sv
// Integer register file with NRP combinational read ports, WB and LR write
// ports, optional same-cycle bypass and a per-register pending scoreboard.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRP*AW-1:0]    rd_addr,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP-1:0]       rd_busy,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 lr_we,
    input  logic [AW-1:0]        lr_addr,
    input  logic [XLEN-1:0]      lr_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    output logic [AW:0]          pend_cnt,
    output logic                 all_clear
);

    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity
    if (NRP < 1 || NRP > 4) begin : g_bad_nrp
        $error("regfile_sb: NRP must be 1..4");
    end
    if (NREG < 2 || NREG > 64 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("regfile_sb: NREG must be a power of two in 2..64");
    end

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            all_clear_q;
    logic            all_clear_d;

    logic            wb_act;
    logic            lr_act;
    logic            lr_wr;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] fall_vec;
    logic            rise;
    logic [1:0]      fall_n;

    // Writes to register 0 are dropped on both ports
    assign wb_act = wb_we && (wb_addr != '0);
    assign lr_act = lr_we && (lr_addr != '0);
    // WB wins a same-address collision; LR data is dropped
    assign lr_wr  = lr_act && !(wb_act && (wb_addr == lr_addr));

    // Register array next state
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (lr_wr) begin
            regs_d[lr_addr] = lr_data;
        end
        if (wb_act) begin
            regs_d[wb_addr] = wb_data;
        end
        regs_d[0] = '0;
    end

    // Scoreboard: a same-cycle issue is younger than the returning write, so set wins
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && (iss_addr != '0)) begin
            set_vec[iss_addr] = 1'b1;
        end
        if (wb_act) begin
            clr_vec[wb_addr] = 1'b1;
        end
        if (lr_act) begin
            clr_vec[lr_addr] = 1'b1;
        end
        pend_d   = set_vec | (pend_q & ~clr_vec);
        fall_vec = pend_q & clr_vec & ~set_vec;
        rise     = |(set_vec & ~pend_q);
    end

    // At most two bits can drop per cycle (one per write port)
    always_comb begin
        fall_n = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            fall_n = fall_n + 2'(fall_vec[i]);
        end
        cnt_d       = cnt_q + CW'(rise) - CW'(fall_n);
        all_clear_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q      <= '0;
            cnt_q       <= '0;
            all_clear_q <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            all_clear_q <= all_clear_d;
        end
    end

    assign pend_cnt  = cnt_q;
    assign all_clear = all_clear_q;

    // Read ports; wb_act/lr_act already exclude address 0 from bypass
    for (genvar k = 0; k < int'(NRP); k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          wb_hit;
        logic          lr_hit;

        assign addr   = rd_addr[k*AW +: AW];
        assign wb_hit = (BYPASS != 0) && wb_act && (wb_addr == addr);
        assign lr_hit = (BYPASS != 0) && lr_act && (lr_addr == addr);

        assign rd_data[k*XLEN +: XLEN] = wb_hit ? wb_data :
                                         lr_hit ? lr_data : regs_q[addr];
        assign rd_busy[k] = pend_q[addr] && !(wb_hit || lr_hit);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassed and a non-bypassed instance
// share stimulus and are compared against an array/queue-level reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;
    localparam int CW   = AW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NRP*AW-1:0]   rd_addr;
    logic                wb_we, lr_we, iss_valid;
    logic [AW-1:0]       wb_addr, lr_addr, iss_addr;
    logic [XLEN-1:0]     wb_data, lr_data;

    logic [NRP*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRP-1:0]      rd_busy_b, rd_busy_n;
    logic [AW:0]         pend_cnt_b, pend_cnt_n;
    logic                all_clear_b, all_clear_n;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lr_we(lr_we), .lr_addr(lr_addr), .lr_data(lr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .pend_cnt(pend_cnt_b), .all_clear(all_clear_b)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lr_we(lr_we), .lr_addr(lr_addr), .lr_data(lr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .pend_cnt(pend_cnt_n), .all_clear(all_clear_n)
    );

    // Reference model state
    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_pend [NREG];
    int              checks = 0;
    int              errors = 0;

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == '0) return '0;
        if (byp && wb_we && wb_addr == a) return wb_data;
        if (byp && lr_we && lr_addr == a) return lr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == '0) return 1'b0;
        if (byp && ((wb_we && wb_addr == a) || (lr_we && lr_addr == a))) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int a = 0; a < NREG; a++) n += int'(m_pend[a]);
        return n;
    endfunction

    // Advance model with the current inputs, then clock the DUTs
    task automatic step();
        bit np [NREG];
        if (!rst) begin
            for (int a = 0; a < NREG; a++) begin
                m_mem[a]  = '0;
                m_pend[a] = 1'b0;
            end
        end else begin
            for (int a = 1; a < NREG; a++) begin
                np[a] = m_pend[a];
                if ((wb_we && int'(wb_addr) == a) || (lr_we && int'(lr_addr) == a)) np[a] = 1'b0;
                if (iss_valid && int'(iss_addr) == a) np[a] = 1'b1;
            end
            if (lr_we && lr_addr != '0) m_mem[lr_addr] = lr_data;
            if (wb_we && wb_addr != '0) m_mem[wb_addr] = wb_data;
            for (int a = 1; a < NREG; a++) m_pend[a] = np[a];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; wb_we = 1'b0; lr_we = 1'b0; iss_valid = 1'b0;
        wb_addr = '0; lr_addr = '0; iss_addr = '0; wb_data = '0; lr_data = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic test_reset();
        idle(); set_rd(0, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, NREG - 1 - a);
            #1;
            for (int k = 0; k < NRP; k++) begin
                checks++;
                if (rd_data_b[k*XLEN +: XLEN] !== '0 || rd_data_n[k*XLEN +: XLEN] !== '0) begin
                    errors++;
                    $display("FAIL reset_data a=%0d port=%0d got %h/%h exp 0", a, k,
                             rd_data_b[k*XLEN +: XLEN], rd_data_n[k*XLEN +: XLEN]);
                end
                checks++;
                if (rd_busy_b[k] !== 1'b0 || rd_busy_n[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy a=%0d port=%0d got %b/%b exp 0", a, k, rd_busy_b[k], rd_busy_n[k]);
                end
            end
        end
        checks++;
        if (pend_cnt_b !== '0 || pend_cnt_n !== '0 || all_clear_b !== 1'b1 || all_clear_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt got cnt %0d/%0d clr %b/%b exp 0 and 1", pend_cnt_b, pend_cnt_n, all_clear_b, all_clear_n);
        end
    endtask

    task automatic test_write_basic();
        idle();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0005;
        lr_we = 1'b1; lr_addr = 5'd6; lr_data = 32'h0000_0004;
        step();
        idle(); set_rd(5, 6); #1;
        checks++;
        if (rd_data_b !== {32'h4, 32'h5} || rd_data_n !== {32'h4, 32'h5}) begin
            errors++;
            $display("FAIL write_x5_x6 got %h/%h exp %h", rd_data_b, rd_data_n, {32'h4, 32'h5});
        end
        wb_we = 1'b1; wb_addr = '0; wb_data = 32'hFFFF_FFFF; set_rd(0, 0); #1;
        checks++;
        if (rd_data_b !== '0) begin
            errors++;
            $display("FAIL x0_no_bypass got %h exp 0", rd_data_b);
        end
        step();
        idle(); #1;
        checks++;
        if (rd_data_b !== '0 || rd_data_n !== '0) begin
            errors++;
            $display("FAIL x0_write got %h/%h exp 0", rd_data_b, rd_data_n);
        end
    endtask

    task automatic test_bypass();
        idle(); wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
        step();
        idle();
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAAAA_0000;
        lr_we = 1'b1; lr_addr = 5'd7; lr_data = 32'h0000_5555;
        set_rd(7, 6); #1;
        checks++;
        if (rd_data_b[XLEN-1:0] !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL bypass_wb_prio got %h exp aaaa0000", rd_data_b[XLEN-1:0]);
        end
        checks++;
        if (rd_data_n[XLEN-1:0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL nobypass_old got %h exp 12345678", rd_data_n[XLEN-1:0]);
        end
        step();
        idle(); #1;
        checks++;
        if (rd_data_b[XLEN-1:0] !== 32'hAAAA_0000 || rd_data_n[XLEN-1:0] !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL collide_store got %h/%h exp aaaa0000", rd_data_b[XLEN-1:0], rd_data_n[XLEN-1:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle(); iss_valid = 1'b1; iss_addr = 5'd3;
        step();
        idle(); #1;
        checks++;
        if (pend_cnt_b !== CW'(1) || pend_cnt_n !== CW'(1)) begin
            errors++;
            $display("FAIL sb_cnt1 got %0d/%0d exp 1", pend_cnt_b, pend_cnt_n);
        end
        iss_valid = 1'b1; iss_addr = 5'd4;
        step();
        idle(); set_rd(3, 4); #1;
        checks++;
        if (pend_cnt_b !== CW'(2) || rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11 || all_clear_b !== 1'b0) begin
            errors++;
            $display("FAIL sb_cnt2 got cnt %0d busy %b/%b clr %b exp 2 11 11 0", pend_cnt_b, rd_busy_b, rd_busy_n, all_clear_b);
        end
        lr_we = 1'b1; lr_addr = 5'd3; lr_data = 32'h33; #1;
        checks++;
        if (rd_busy_b !== 2'b10 || rd_busy_n !== 2'b11) begin
            errors++;
            $display("FAIL sb_lr_bypass_busy got %b/%b exp 10/11", rd_busy_b, rd_busy_n);
        end
        step();
        idle(); #1;
        checks++;
        if (rd_busy_b !== 2'b10 || pend_cnt_b !== CW'(1) || rd_data_b[XLEN-1:0] !== 32'h33) begin
            errors++;
            $display("FAIL sb_lr_clear got busy %b cnt %0d data %h exp 10 1 33", rd_busy_b, pend_cnt_b, rd_data_b[XLEN-1:0]);
        end
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44; set_rd(0, 4); #1;
        checks++;
        if (rd_busy_b[1] !== 1'b0 || rd_busy_n[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_wb_bypass_busy got %b/%b exp 0/1", rd_busy_b[1], rd_busy_n[1]);
        end
        step();
        idle(); #1;
        checks++;
        if (pend_cnt_b !== '0 || pend_cnt_n !== '0 || all_clear_b !== 1'b1 || all_clear_n !== 1'b1) begin
            errors++;
            $display("FAIL sb_drain got cnt %0d/%0d clr %b/%b exp 0 and 1", pend_cnt_b, pend_cnt_n, all_clear_b, all_clear_n);
        end
    endtask

    task automatic test_set_clear_same();
        idle(); iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        lr_we = 1'b1; lr_addr = 5'd9; lr_data = 32'h99;
        set_rd(9, 9);
        step();
        idle(); #1;
        checks++;
        if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11 || pend_cnt_b !== CW'(1) || pend_cnt_n !== CW'(1)) begin
            errors++;
            $display("FAIL set_wins got busy %b/%b cnt %0d/%0d exp 11 11 1 1", rd_busy_b, rd_busy_n, pend_cnt_b, pend_cnt_n);
        end
        checks++;
        if (rd_data_b[XLEN-1:0] !== 32'h99 || rd_data_n[XLEN-1:0] !== 32'h99) begin
            errors++;
            $display("FAIL set_wins_data got %h/%h exp 99", rd_data_b[XLEN-1:0], rd_data_n[XLEN-1:0]);
        end
        iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        idle(); #1;
        checks++;
        if (pend_cnt_b !== CW'(1)) begin
            errors++;
            $display("FAIL reissue_cnt got %0d exp 1", pend_cnt_b);
        end
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int a = 1; a <= 3; a++) begin
            iss_valid = 1'b1; iss_addr = AW'(a);
            step();
        end
        idle(); #1;
        checks++;
        if (pend_cnt_b !== CW'(3)) begin
            errors++;
            $display("FAIL mid_cnt3 got %0d exp 3", pend_cnt_b);
        end
        rst = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD;
        lr_we = 1'b1; lr_addr = 5'd2; lr_data = 32'hBEEF;
        iss_valid = 1'b1; iss_addr = 5'd5;
        step();
        idle();
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, a); #1;
            checks++;
            if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0 || rd_busy_n !== '0) begin
                errors++;
                $display("FAIL mid_reset a=%0d got %h/%h busy %b/%b exp all 0", a, rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
            end
        end
        checks++;
        if (pend_cnt_b !== '0 || all_clear_b !== 1'b1 || pend_cnt_n !== '0 || all_clear_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_cnt got %0d/%0d clr %b/%b exp 0 and 1", pend_cnt_b, pend_cnt_n, all_clear_b, all_clear_n);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 5));
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) != 0);
            wb_we     = ($urandom_range(0, 2) == 0);
            lr_we     = ($urandom_range(0, 2) == 0);
            iss_valid = ($urandom_range(0, 1) == 0);
            wb_addr   = rnd_addr();
            lr_addr   = rnd_addr();
            iss_addr  = rnd_addr();
            wb_data   = $urandom;
            lr_data   = $urandom;
            rd_addr   = {rnd_addr(), rnd_addr()};
            #1;
            for (int k = 0; k < NRP; k++) begin
                a = rd_addr[k*AW +: AW];
                checks++;
                if (rd_data_b[k*XLEN +: XLEN] !== exp_data(a, 1'b1) ||
                    rd_data_n[k*XLEN +: XLEN] !== exp_data(a, 1'b0)) begin
                    errors++;
                    $display("FAIL rnd_data n=%0d port=%0d a=%0d got %h/%h exp %h/%h", n, k, a,
                             rd_data_b[k*XLEN +: XLEN], rd_data_n[k*XLEN +: XLEN],
                             exp_data(a, 1'b1), exp_data(a, 1'b0));
                end
                checks++;
                if (rd_busy_b[k] !== exp_busy(a, 1'b1) || rd_busy_n[k] !== exp_busy(a, 1'b0)) begin
                    errors++;
                    $display("FAIL rnd_busy n=%0d port=%0d a=%0d got %b/%b exp %b/%b", n, k, a,
                             rd_busy_b[k], rd_busy_n[k], exp_busy(a, 1'b1), exp_busy(a, 1'b0));
                end
            end
            checks++;
            if (pend_cnt_b !== CW'(exp_cnt()) || pend_cnt_n !== CW'(exp_cnt()) ||
                all_clear_b !== (exp_cnt() == 0) || all_clear_n !== (exp_cnt() == 0)) begin
                errors++;
                $display("FAIL rnd_cnt n=%0d got %0d/%0d clr %b/%b exp %0d", n, pend_cnt_b, pend_cnt_n,
                         all_clear_b, all_clear_n, exp_cnt());
            end
            step();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        set_rd(0, 0);
        test_reset();
        test_write_basic();
        test_bypass();
        test_scoreboard();
        test_set_clear_same();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
